clk_set_ctrl: RTL

- Button-driven time-setting controller for the real-time clock core.
- Converts mode/inc/dec button presses into a field-by-field edit sequence: hours, then minutes, then seconds.
- Each field is committed through the core's load/address/data write port as a single-cycle write.
- Sits between the debounced button front end and the clock core, and also drives display edit/blink indication.

---
 rtl/clk_set_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/clk_set_ctrl.sv
// Button-driven time-setting controller: walks hours -> minutes -> seconds,
// committing each field to the clock core as a single-cycle write.
module clk_set_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000000000,
    parameter int BLINK_CYCLES   = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [5:0] seconds_in,
    input  logic [5:0] minutes_in,
    input  logic [4:0] hours_in,
    output logic       load,
    output logic [1:0] addrs,
    output logic [5:0] data_out,
    output logic       editing,
    output logic [1:0] edit_field,
    output logic [5:0] edit_value,
    output logic       blink
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);
    localparam logic [5:0] HOUR_MAX   = 6'd23;
    localparam logic [5:0] MINSEC_MAX = 6'd59;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        EDIT_H = 2'b01,
        EDIT_M = 2'b10,
        EDIT_S = 2'b11
    } state_t;

    state_t          state, state_nx;
    logic            mode_q, inc_q, dec_q;
    logic [TO_W-1:0] to_cnt, to_nx;
    logic [BL_W-1:0] bl_cnt, bl_nx;
    logic            load_nx, editing_nx, blink_nx;
    logic [1:0]      addrs_nx, field_nx;
    logic [5:0]      data_nx, value_nx;
    logic [5:0]      cur_lim;
    logic            mode_p, inc_p, dec_p;

    // Saturate a corrupt core value to the field limit on capture.
    function automatic logic [5:0] clamp_val(input logic [5:0] v, input logic [5:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] lim);
        return (v >= lim) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] lim);
        return (v == 6'd0) ? lim : v - 6'd1;
    endfunction

    // Field code shared by addrs and edit_field; 2'b11 means no field.
    function automatic logic [1:0] field_of(input state_t s);
        case (s)
            EDIT_H:  return 2'b10;
            EDIT_M:  return 2'b01;
            EDIT_S:  return 2'b00;
            default: return 2'b11;
        endcase
    endfunction

    assign mode_p  = btn_mode & ~mode_q;
    assign inc_p   = btn_inc & ~inc_q;
    assign dec_p   = btn_dec & ~dec_q;
    assign cur_lim = (state == EDIT_H) ? HOUR_MAX : MINSEC_MAX;

    always_comb begin
        state_nx = state;
        load_nx  = 1'b0;
        addrs_nx = addrs;
        data_nx  = data_out;
        value_nx = edit_value;
        to_nx    = to_cnt;
        bl_nx    = bl_cnt;
        blink_nx = blink;

        case (state)
            IDLE: begin
                if (mode_p) begin
                    state_nx = EDIT_H;
                    value_nx = clamp_val({1'b0, hours_in}, HOUR_MAX);
                    to_nx    = '0;
                    bl_nx    = '0;
                    blink_nx = 1'b1;
                end
            end
            default: begin
                if (mode_p) begin
                    // Commit the value held before this edge, then advance.
                    load_nx  = 1'b1;
                    addrs_nx = field_of(state);
                    data_nx  = edit_value;
                    to_nx    = '0;
                    bl_nx    = '0;
                    blink_nx = 1'b1;
                    case (state)
                        EDIT_H: begin
                            state_nx = EDIT_M;
                            value_nx = clamp_val(minutes_in, MINSEC_MAX);
                        end
                        EDIT_M: begin
                            state_nx = EDIT_S;
                            value_nx = clamp_val(seconds_in, MINSEC_MAX);
                        end
                        default: begin
                            state_nx = IDLE;
                            value_nx = 6'd0;
                            blink_nx = 1'b0;
                        end
                    endcase
                end else begin
                    if (bl_cnt == BL_LAST) begin
                        bl_nx    = '0;
                        blink_nx = ~blink;
                    end else begin
                        bl_nx = bl_cnt + BL_W'(1);
                    end

                    if (inc_p || dec_p) begin
                        to_nx = '0;
                        if (inc_p && !dec_p)
                            value_nx = wrap_inc(edit_value, cur_lim);
                        else if (dec_p && !inc_p)
                            value_nx = wrap_dec(edit_value, cur_lim);
                    end else if (to_cnt == TO_LAST) begin
                        // Abandon the edit without writing the current field.
                        state_nx = IDLE;
                        to_nx    = '0;
                        bl_nx    = '0;
                        blink_nx = 1'b0;
                        value_nx = 6'd0;
                    end else begin
                        to_nx = to_cnt + TO_W'(1);
                    end
                end
            end
        endcase

        editing_nx = (state_nx != IDLE);
        field_nx   = field_of(state_nx);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            to_cnt     <= '0;
            bl_cnt     <= '0;
            load       <= 1'b0;
            addrs      <= 2'b00;
            data_out   <= 6'd0;
            editing    <= 1'b0;
            edit_field <= 2'b11;
            edit_value <= 6'd0;
            blink      <= 1'b0;
        end else begin
            state      <= state_nx;
            mode_q     <= btn_mode;
            inc_q      <= btn_inc;
            dec_q      <= btn_dec;
            to_cnt     <= to_nx;
            bl_cnt     <= bl_nx;
            load       <= load_nx;
            addrs      <= addrs_nx;
            data_out   <= data_nx;
            editing    <= editing_nx;
            edit_field <= field_nx;
            edit_value <= value_nx;
            blink      <= blink_nx;
        end
    end

endmodule
